flag_branch_unit: RTL and testbench

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

---
 rtl/flag_branch_unit.sv | 182 ++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Condition-flag register and branch resolver. Branches stall in decode until no flag writer is in flight.
// Optional macro FLAG_BYPASS_EN resolves the branch in the same cycle as the last flag write.
module flag_branch_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [3:0]       dec_opcode,
  input  logic [2:0]       dec_ccc,
  input  logic             dec_set_n,
  input  logic             dec_set_z,
  input  logic             dec_set_v,
  output logic             dec_ready,
  input  logic             ex_flag_valid,
  input  logic             ex_n,
  input  logic             ex_z,
  input  logic             ex_v,
  input  logic             ex_set_n,
  input  logic             ex_set_z,
  input  logic             ex_set_v,
  input  logic             flush,
  output logic             br_valid,
  output logic             br_taken,
  output logic             br_is_reg,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic [CNT_W-1:0] pending,
  output logic             underflow_err
);

  localparam logic [3:0] OP_B  = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             flag_n_q, flag_z_q, flag_v_q;
  logic             flag_n_d, flag_z_d, flag_v_d;
  logic             underflow_q, underflow_d;
  logic             br_valid_q, br_taken_q, br_is_reg_q;
  logic             br_valid_d, br_taken_d, br_is_reg_d;

  logic is_branch, is_writer_ins, full, writer_block;
  logic bypass, resolvable, branch_ok;
  logic accepted, writer, br_fire;
  logic eff_n, eff_z, eff_v, cond;

  assign is_branch     = (dec_opcode == OP_B) || (dec_opcode == OP_BR);
  assign is_writer_ins = dec_set_n | dec_set_z | dec_set_v;
  assign full          = (pending_q == CNT_W'(DEPTH)) && !ex_flag_valid;
  assign writer_block  = is_writer_ins & full;

`ifdef FLAG_BYPASS_EN
  // Last outstanding writer completing now: branch may use its flags directly.
  assign bypass = ex_flag_valid && (pending_q == CNT_W'(1));
  assign eff_n  = (ex_flag_valid & ex_set_n) ? ex_n : flag_n_q;
  assign eff_z  = (ex_flag_valid & ex_set_z) ? ex_z : flag_z_q;
  assign eff_v  = (ex_flag_valid & ex_set_v) ? ex_v : flag_v_q;
`else
  assign bypass = 1'b0;
  assign eff_n  = flag_n_q;
  assign eff_z  = flag_z_q;
  assign eff_v  = flag_v_q;
`endif

  assign resolvable = (pending_q == '0) || bypass;
  assign branch_ok  = resolvable & ~writer_block;

  always_comb begin
    cond = 1'b0;
    case (dec_ccc)
      3'b000: cond = ~eff_z;
      3'b001: cond = eff_z;
      3'b010: cond = ~eff_z & ~eff_n;
      3'b011: cond = eff_n;
      3'b100: cond = eff_z | ~eff_n;
      3'b101: cond = eff_n | eff_z;
      3'b110: cond = eff_v;
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dec_ready = 1'b1;
    case (state_q)
      IDLE: begin
        if (dec_valid && is_branch) begin
          dec_ready = branch_ok;
          if (!branch_ok) state_d = WAIT;
        end else begin
          dec_ready = ~writer_block;
        end
      end
      WAIT: begin
        dec_ready = 1'b0;
        if (dec_valid && is_branch) begin
          if (branch_ok) begin
            dec_ready = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          // Branch withdrawn from decode; nothing left to wait for.
          dec_ready = ~writer_block;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign accepted = dec_valid & dec_ready & ~flush;
  assign writer   = accepted & is_writer_ins;
  assign br_fire  = accepted & is_branch;

  always_comb begin
    pending_d   = pending_q;
    underflow_d = underflow_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    br_valid_d  = br_fire;
    br_taken_d  = br_fire & cond;
    br_is_reg_d = br_fire & (dec_opcode == OP_BR);
    if (flush) begin
      pending_d = '0;
    end else begin
      if (ex_flag_valid) begin
        if (ex_set_n) flag_n_d = ex_n;
        if (ex_set_z) flag_z_d = ex_z;
        if (ex_set_v) flag_v_d = ex_v;
      end
      case ({writer, ex_flag_valid})
        2'b10: pending_d = pending_q + CNT_W'(1);
        2'b01: begin
          if (pending_q == '0) underflow_d = 1'b1;
          else                 pending_d   = pending_q - CNT_W'(1);
        end
        default: pending_d = pending_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      underflow_q <= 1'b0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_is_reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      underflow_q <= underflow_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      br_is_reg_q <= br_is_reg_d;
    end
  end

  assign br_valid      = br_valid_q;
  assign br_taken      = br_taken_q;
  assign br_is_reg     = br_is_reg_q;
  assign flag_n        = flag_n_q;
  assign flag_z        = flag_z_q;
  assign flag_v        = flag_v_q;
  assign pending       = pending_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit; branch outcomes are checked through an expected-result queue.
module tb_flag_branch_unit;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_ADD = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [3:0] dec_opcode;
  logic [2:0] dec_ccc;
  logic       dec_set_n, dec_set_z, dec_set_v;
  logic       dec_ready;
  logic       ex_flag_valid, ex_n, ex_z, ex_v, ex_set_n, ex_set_z, ex_set_v;
  logic       flush;
  logic       br_valid, br_taken, br_is_reg;
  logic       flag_n, flag_z, flag_v;
  logic [2:0] pending;
  logic       underflow_err;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  flag_branch_unit #(.DEPTH(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_ccc(dec_ccc),
    .dec_set_n(dec_set_n), .dec_set_z(dec_set_z), .dec_set_v(dec_set_v),
    .dec_ready(dec_ready),
    .ex_flag_valid(ex_flag_valid), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v),
    .ex_set_n(ex_set_n), .ex_set_z(ex_set_z), .ex_set_v(ex_set_v),
    .flush(flush),
    .br_valid(br_valid), .br_taken(br_taken), .br_is_reg(br_is_reg),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .pending(pending), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    dec_valid = 1'b0; dec_opcode = 4'h0; dec_ccc = 3'b000;
    dec_set_n = 1'b0; dec_set_z = 1'b0; dec_set_v = 1'b0;
  endtask

  task automatic clr_ex();
    ex_flag_valid = 1'b0; ex_n = 1'b0; ex_z = 1'b0; ex_v = 1'b0;
    ex_set_n = 1'b0; ex_set_z = 1'b0; ex_set_v = 1'b0;
  endtask

  // Scoreboard: every br_valid pulse must match the oldest queued {taken, is_reg}.
  always @(negedge clk) begin
    if (!rst && br_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_br_valid", 8'(br_valid), 8'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("br_taken", 8'(br_taken), 8'(e[1]));
        check("br_is_reg", 8'(br_is_reg), 8'(e[0]));
      end
    end
  end

  initial begin
    logic [7:0] tab;
    tab = 8'b1010_1001;  // outcome per ccc with N=1, Z=0, V=0
    rst = 1'b1; flush = 1'b0;
    clr_dec(); clr_ex();
    tick(); tick();

    // Reset state
    check("rst_pending", 8'(pending), 8'd0);
    check("rst_flags", 8'({flag_n, flag_z, flag_v}), 8'd0);
    check("rst_br", 8'({br_valid, br_taken, br_is_reg}), 8'd0);
    check("rst_underflow", 8'(underflow_err), 8'd0);
    check("rst_ready", 8'(dec_ready), 8'd1);
    rst = 1'b0;
    tick();

    // Unconditional B with nothing pending
    dec_valid = 1'b1; dec_opcode = OP_B; dec_ccc = 3'b111;
    #1 check("b_always_ready", 8'(dec_ready), 8'd1);
    exp_q.push_back(2'b10);
    tick();
    clr_dec();
    check("b_always_valid", 8'(br_valid), 8'd1);
    tick();
    check("b_always_pulse", 8'(br_valid), 8'd0);

    // ADD setting all flags, then B Z=1 waiting on it
    dec_valid = 1'b1; dec_opcode = OP_ADD;
    dec_set_n = 1'b1; dec_set_z = 1'b1; dec_set_v = 1'b1;
    #1 check("add_ready", 8'(dec_ready), 8'd1);
    tick();
    check("add_pending", 8'(pending), 8'd1);
    clr_dec();
    dec_valid = 1'b1; dec_opcode = OP_B; dec_ccc = 3'b001;
    #1 check("beq_stall1", 8'(dec_ready), 8'd0);
    exp_q.push_back(2'b10);
    tick();
    ex_flag_valid = 1'b1; ex_z = 1'b1; ex_set_n = 1'b1; ex_set_z = 1'b1; ex_set_v = 1'b1;
`ifdef FLAG_BYPASS_EN
    #1 check("beq_bypass_ready", 8'(dec_ready), 8'd1);
    tick();
    clr_ex(); clr_dec();
`else
    #1 check("beq_stall2", 8'(dec_ready), 8'd0);
    tick();
    clr_ex();
    #1 check("beq_ready", 8'(dec_ready), 8'd1);
    tick();
    clr_dec();
`endif
    check("beq_valid", 8'(br_valid), 8'd1);
    check("beq_flag_z", 8'(flag_z), 8'd1);
    check("beq_pending", 8'(pending), 8'd0);
    tick();

    // Fill to DEPTH, then a third writer against a completing one
    dec_valid = 1'b1; dec_opcode = OP_ADD; dec_set_n = 1'b1;
    #1 check("w1_ready", 8'(dec_ready), 8'd1);
    tick();
    check("w1_pending", 8'(pending), 8'd1);
    tick();
    check("w2_pending", 8'(pending), 8'd2);
    #1 check("full_ready", 8'(dec_ready), 8'd0);
    tick();
    check("full_hold", 8'(pending), 8'd2);
    ex_flag_valid = 1'b1; ex_n = 1'b1; ex_set_n = 1'b1;
    ex_z = 1'b0; ex_set_z = 1'b1; ex_v = 1'b1; ex_set_v = 1'b0;
    #1 check("full_ex_ready", 8'(dec_ready), 8'd1);
    tick();
    check("same_cycle_pending", 8'(pending), 8'd2);
    clr_dec();
    tick();
    check("drain1_pending", 8'(pending), 8'd1);
    tick();
    check("drain0_pending", 8'(pending), 8'd0);
    clr_ex();
    check("flags_nzv", 8'({flag_n, flag_z, flag_v}), 8'b100);
    check("no_underflow", 8'(underflow_err), 8'd0);

    // Every condition code back to back with N=1, Z=0, V=0
    for (int i = 0; i < 8; i++) begin
      logic [2:0] c;
      c = 3'(i);
      dec_valid = 1'b1; dec_opcode = c[0] ? OP_BR : OP_B; dec_ccc = c;
      #1 check("ccc_ready", 8'(dec_ready), 8'd1);
      exp_q.push_back({tab[i], c[0]});
      tick();
    end
    clr_dec();
    tick(); tick();

    // Completion with nothing pending
    ex_flag_valid = 1'b1;
    tick();
    clr_ex();
    check("uf_pending", 8'(pending), 8'd0);
    check("uf_err", 8'(underflow_err), 8'd1);
    tick();
    check("uf_sticky", 8'(underflow_err), 8'd1);

    // Flush a BR waiting on a writer
    dec_valid = 1'b1; dec_opcode = OP_ADD; dec_set_v = 1'b1;
    tick();
    clr_dec();
    dec_valid = 1'b1; dec_opcode = OP_BR; dec_ccc = 3'b110;
    #1 check("brv_stall", 8'(dec_ready), 8'd0);
    tick(); tick();
    flush = 1'b1; clr_dec();
    tick();
    flush = 1'b0;
    check("flush_pending", 8'(pending), 8'd0);
    check("flush_uf_hold", 8'(underflow_err), 8'd1);
    check("flush_flag_hold", 8'(flag_n), 8'd1);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_br", 8'(br_valid), 8'd0);
      tick();
    end
    dec_valid = 1'b1; dec_opcode = OP_B; dec_ccc = 3'b111;
    #1 check("flush_idle_ready", 8'(dec_ready), 8'd1);
    exp_q.push_back(2'b10);
    tick();
    clr_dec();
    tick();

    // Reset in the middle of a stalled branch
    dec_valid = 1'b1; dec_opcode = OP_ADD; dec_set_z = 1'b1;
    tick();
    clr_dec();
    dec_valid = 1'b1; dec_opcode = OP_B; dec_ccc = 3'b000;
    #1 check("rw_stall", 8'(dec_ready), 8'd0);
    tick();
    rst = 1'b1; clr_dec();
    #1;
    check("rw_pending", 8'(pending), 8'd0);
    check("rw_flags", 8'({flag_n, flag_z, flag_v}), 8'd0);
    check("rw_underflow", 8'(underflow_err), 8'd0);
    check("rw_ready", 8'(dec_ready), 8'd1);
    check("rw_br0", 8'(br_valid), 8'd0);
    tick();
    check("rw_br1", 8'(br_valid), 8'd0);
    rst = 1'b0;
    tick();
    check("rw_br2", 8'(br_valid), 8'd0);
    tick();

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
